spi_frame_sequencer: RTL
========================

Name: spi_frame_sequencer

Overview:
- Sits directly upstream of the SPI master byte engine and turns a FIFO of TX bytes into one multi-byte SPI frame with an active-low slave select.
- Drives the engine's start/data inputs and consumes its newData/data outputs, collecting received bytes into an RX FIFO.
- The host pushes bytes, pulses frame_go, and pops replies.

Parameters:
- DATAWIDTH_BUS, 8, byte width; matches the engine's data width.
- FIFO_ADDR, 2, FIFO address bits; TX and RX depth = 2**FIFO_ADDR (4).
- SETUP_CYCLES, 4, clocks from SS low to the first start pulse (1..15).
- GAP_CYCLES, 2, idle clocks between consecutive bytes, and from the last newData to SS high (1..15).
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT_DONE; used only with the optional feature.

Ports:
- SPI_MASTER_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SPI_MASTER_RESET_InHigh  in  1  asynchronous, active-high reset.
- SEQ_txWrite_InHigh  in  1  push tx_data into the TX FIFO.
- SEQ_txData_In  in  DATAWIDTH_BUS  byte to push.
- SEQ_txFull_Out  out  1  TX FIFO full.
- SEQ_frameGo_InHigh  in  1  start a frame that sends every byte currently in the TX FIFO.
- SEQ_rxRead_InHigh  in  1  pop the RX FIFO.
- SEQ_rxData_Out  out  DATAWIDTH_BUS  RX FIFO head (show-ahead).
- SEQ_rxEmpty_Out  out  1  RX FIFO empty.
- SEQ_frameDone_Out  out  1  one-cycle pulse at the end of a frame.
- SEQ_rxOverrun_Out  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- SEQ_SS_OutLow  out  1  slave select, active low.
- SEQ_start_Out  out  1  to engine start input.
- SEQ_data_Out  out  DATAWIDTH_BUS  to engine data input.
- SEQ_newData_In  in  1  from engine newData.
- SEQ_data_In  in  DATAWIDTH_BUS  from engine data output; valid in the cycle newData=1.
- SEQ_busy_Out  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state IDLE; SS_OutLow=1; start=0; data_Out=0; frameDone=0; rxOverrun=0; busy=0.
- Reset also empties both FIFOs (txFull=0, rxEmpty=1, rxData_Out=0).
- Reset mid-frame aborts immediately; SS goes high asynchronously.
- All outputs are registered.
- FIFOs:
  - Circular buffers with FIFO_ADDR-bit pointers that wrap modulo depth, plus an (FIFO_ADDR+1)-bit count.
  - A write when full is ignored.
  - A read when empty is ignored.
  - A simultaneous write and read on the TX FIFO while it is full is legal; the count is unchanged.
- FSM:
  - IDLE: on frameGo=1 with TX count>0, latch bytes_left=TX count, clear rxOverrun, go to SETUP with SS low the next cycle. frameGo with an empty TX FIFO is ignored. frameGo in any other state is ignored.
  - SETUP: wait SETUP_CYCLES clocks, then go to LOAD.
  - LOAD (1 cycle): pop the TX head into data_Out, assert start=1 for exactly this one registered cycle, go to WAIT_DONE.
  - WAIT_DONE: hold data_Out and SS stable. On newData=1, push data_In into the RX FIFO, or set rxOverrun if it is full. Then decrement bytes_left and go to GAP.
  - GAP: wait GAP_CYCLES clocks. Go to LOAD if bytes_left>0, else to HOLD.
  - HOLD (1 cycle): SS_OutLow=1, frameDone=1, go to IDLE.
- TX bytes pushed after frameGo are not part of the current frame; bytes_left is fixed at launch.
- Host rx reads during a frame are allowed. A same-cycle RX push and host pop while full is legal (no overrun).
- Latency: frameGo at cycle 0 → SS low at cycle 1 → first start at cycle 1+SETUP_CYCLES.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts in WAIT_DONE and is cleared on entry.
  - If it reaches TIMEOUT_CYCLES without newData, the frame aborts: SS high, TX FIFO flushed, frameDone pulses, and a sticky port SEQ_timeout_Out (out, 1) sets.
  - SEQ_timeout_Out clears on the next accepted frameGo; reset value 0.
- Undefined: no watchdog and no SEQ_timeout_Out port; WAIT_DONE waits indefinitely.

Test Plan:
- Push 0xA5, frameGo; engine model returns 0x3C → SS low for the whole frame, one start pulse with data_Out=0xA5, rxData=0x3C, rxEmpty=0, frameDone pulse, SS high.
- Push 0x01,0x02,0x03,0x04 (txFull=1), push 0x05 → 0x05 is dropped. frameGo → 4 start pulses with ≥GAP_CYCLES spacing; SS stays low throughout; RX holds 4 bytes in order.
- RX pre-filled with 4 unread bytes, run a 1-byte frame → rxOverrun=1, RX contents unchanged; next frameGo clears rxOverrun.
- frameGo with an empty TX FIFO → SS stays 1, busy stays 0, no frameDone. frameGo during WAIT_DONE → ignored, byte count unchanged.
- Assert reset during WAIT_DONE of byte 2 of 3 → SS=1 and start=0 immediately, both FIFOs empty, state IDLE.
- With SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20: never assert newData → at the 20th WAIT_DONE cycle the frame aborts, SEQ_timeout_Out=1, frameDone pulses, txFull=0.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// -----------------------------------------------------------------------------
// spi_frame_sequencer
// Turns the contents of a small TX FIFO into one multi-byte SPI frame. The
// frame is framed by an active-low slave select and fed one byte at a time
// into the SPI master byte engine. Replies from the engine are collected into
// an RX FIFO that the host reads show-ahead.
//
// Optional feature: define SPI_SEQ_TIMEOUT_EN to add a watchdog on the engine
// handshake and the sticky SEQ_timeout_Out port. The default build has neither.
// -----------------------------------------------------------------------------
module spi_frame_sequencer #(
   parameter int DATAWIDTH_BUS  = 8,
   parameter int FIFO_ADDR      = 2,
   parameter int SETUP_CYCLES   = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     SPI_MASTER_CLOCK_50,
   input  logic                     SPI_MASTER_RESET_InHigh,
   input  logic                     SEQ_txWrite_InHigh,
   input  logic [DATAWIDTH_BUS-1:0] SEQ_txData_In,
   output logic                     SEQ_txFull_Out,
   input  logic                     SEQ_frameGo_InHigh,
   input  logic                     SEQ_rxRead_InHigh,
   output logic [DATAWIDTH_BUS-1:0] SEQ_rxData_Out,
   output logic                     SEQ_rxEmpty_Out,
   output logic                     SEQ_frameDone_Out,
   output logic                     SEQ_rxOverrun_Out,
   output logic                     SEQ_SS_OutLow,
   output logic                     SEQ_start_Out,
   output logic [DATAWIDTH_BUS-1:0] SEQ_data_Out,
   input  logic                     SEQ_newData_In,
   input  logic [DATAWIDTH_BUS-1:0] SEQ_data_In,
`ifdef SPI_SEQ_TIMEOUT_EN
   output logic                     SEQ_timeout_Out,
`endif
   output logic                     SEQ_busy_Out
);

   localparam int DEPTH = 2 ** FIFO_ADDR;
   localparam logic [FIFO_ADDR:0]   CNT_ZERO_C   = (FIFO_ADDR+1)'(0);
   localparam logic [FIFO_ADDR:0]   CNT_ONE_C    = (FIFO_ADDR+1)'(1);
   localparam logic [FIFO_ADDR:0]   CNT_FULL_C   = (FIFO_ADDR+1)'(DEPTH);
   localparam logic [FIFO_ADDR-1:0] PTR_ZERO_C   = FIFO_ADDR'(0);
   localparam logic [FIFO_ADDR-1:0] PTR_ONE_C    = FIFO_ADDR'(1);
   localparam logic [3:0]           SETUP_LAST_C = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0]           GAP_LAST_C   = 4'(GAP_CYCLES - 1);
   localparam logic [DATAWIDTH_BUS-1:0] BYTE_ZERO_C = DATAWIDTH_BUS'(0);
`ifdef SPI_SEQ_TIMEOUT_EN
   localparam logic [7:0]           TO_LAST_C    = 8'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETUP     = 3'd1,
      ST_LOAD      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4,
      ST_HOLD      = 3'd5
   } state_t;

   // Sequencer state and registered outputs
   state_t                   state_r;
   logic [3:0]               wait_cnt_r;
   logic [FIFO_ADDR:0]       bytes_left_r;
   logic                     ss_r;
   logic                     start_r;
   logic [DATAWIDTH_BUS-1:0] data_r;
   logic                     frame_done_r;
   logic                     overrun_r;
   logic                     busy_r;
`ifdef SPI_SEQ_TIMEOUT_EN
   logic [7:0]               wd_r;
   logic                     timeout_r;
`endif

   // TX FIFO
   logic [DATAWIDTH_BUS-1:0] tx_mem_r [DEPTH];
   logic [FIFO_ADDR-1:0]     tx_wr_ptr_r;
   logic [FIFO_ADDR-1:0]     tx_rd_ptr_r;
   logic [FIFO_ADDR:0]       tx_count_r;
   logic                     tx_full_r;

   // RX FIFO
   logic [DATAWIDTH_BUS-1:0] rx_mem_r [DEPTH];
   logic [FIFO_ADDR-1:0]     rx_wr_ptr_r;
   logic [FIFO_ADDR-1:0]     rx_rd_ptr_r;
   logic [FIFO_ADDR:0]       rx_count_r;
   logic                     rx_empty_r;
   logic [DATAWIDTH_BUS-1:0] rx_head_r;

   // Combinational control
   logic                     go_accept_s;
   logic                     load_evt_s;
   logic                     tx_flush_s;
   logic                     tx_push_s;
   logic                     tx_pop_s;
   logic [FIFO_ADDR:0]       tx_count_nxt_s;
   logic                     rx_new_s;
   logic                     rx_push_s;
   logic                     rx_pop_s;
   logic                     overrun_evt_s;
   logic [FIFO_ADDR:0]       rx_count_nxt_s;
   logic [FIFO_ADDR-1:0]     rx_rd_ptr_nxt_s;
   logic [DATAWIDTH_BUS-1:0] rx_head_nxt_s;

   // Frame launch, byte load and abort decisions shared by the FSM and FIFOs
   always_comb begin
      go_accept_s = (state_r == ST_IDLE) && SEQ_frameGo_InHigh && (tx_count_r != CNT_ZERO_C);
      load_evt_s  = ((state_r == ST_SETUP) && (wait_cnt_r == SETUP_LAST_C)) ||
                    ((state_r == ST_GAP) && (wait_cnt_r == GAP_LAST_C) && (bytes_left_r != CNT_ZERO_C));
`ifdef SPI_SEQ_TIMEOUT_EN
      tx_flush_s  = (state_r == ST_WAIT_DONE) && !SEQ_newData_In && (wd_r == TO_LAST_C);
`else
      tx_flush_s  = 1'b0;
`endif
   end

   // TX FIFO handshakes: a push while full is accepted only if a pop frees a slot
   always_comb begin
      tx_pop_s  = load_evt_s && (tx_count_r != CNT_ZERO_C);
      tx_push_s = SEQ_txWrite_InHigh && ((tx_count_r != CNT_FULL_C) || tx_pop_s);
      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_count_nxt_s = tx_count_r + CNT_ONE_C;
         2'b01:   tx_count_nxt_s = tx_count_r - CNT_ONE_C;
         default: tx_count_nxt_s = tx_count_r;
      endcase
   end

   // RX FIFO handshakes and the next show-ahead head value
   always_comb begin
      rx_new_s      = (state_r == ST_WAIT_DONE) && SEQ_newData_In;
      rx_pop_s      = SEQ_rxRead_InHigh && (rx_count_r != CNT_ZERO_C);
      rx_push_s     = rx_new_s && ((rx_count_r != CNT_FULL_C) || rx_pop_s);
      overrun_evt_s = rx_new_s && !rx_push_s;
      case ({rx_push_s, rx_pop_s})
         2'b10:   rx_count_nxt_s = rx_count_r + CNT_ONE_C;
         2'b01:   rx_count_nxt_s = rx_count_r - CNT_ONE_C;
         default: rx_count_nxt_s = rx_count_r;
      endcase
      if (rx_pop_s) begin
         rx_rd_ptr_nxt_s = rx_rd_ptr_r + PTR_ONE_C;
      end else begin
         rx_rd_ptr_nxt_s = rx_rd_ptr_r;
      end
      if (rx_count_nxt_s == CNT_ZERO_C) begin
         rx_head_nxt_s = BYTE_ZERO_C;
      end else if (rx_push_s && (rx_wr_ptr_r == rx_rd_ptr_nxt_s)) begin
         rx_head_nxt_s = SEQ_data_In;
      end else begin
         rx_head_nxt_s = rx_mem_r[rx_rd_ptr_nxt_s];
      end
   end

   // TX FIFO storage, pointers and registered full flag
   always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
      if (SPI_MASTER_RESET_InHigh) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem_r[i] <= BYTE_ZERO_C;
         end
         tx_wr_ptr_r <= PTR_ZERO_C;
         tx_rd_ptr_r <= PTR_ZERO_C;
         tx_count_r  <= CNT_ZERO_C;
         tx_full_r   <= 1'b0;
      end else if (tx_flush_s) begin
         tx_wr_ptr_r <= PTR_ZERO_C;
         tx_rd_ptr_r <= PTR_ZERO_C;
         tx_count_r  <= CNT_ZERO_C;
         tx_full_r   <= 1'b0;
      end else begin
         if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= SEQ_txData_In;
            tx_wr_ptr_r           <= tx_wr_ptr_r + PTR_ONE_C;
         end
         if (tx_pop_s) begin
            tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE_C;
         end
         tx_count_r <= tx_count_nxt_s;
         tx_full_r  <= (tx_count_nxt_s == CNT_FULL_C);
      end
   end

   // RX FIFO storage, pointers, registered empty flag and show-ahead head
   always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
      if (SPI_MASTER_RESET_InHigh) begin
         for (int i = 0; i < DEPTH; i++) begin
            rx_mem_r[i] <= BYTE_ZERO_C;
         end
         rx_wr_ptr_r <= PTR_ZERO_C;
         rx_rd_ptr_r <= PTR_ZERO_C;
         rx_count_r  <= CNT_ZERO_C;
         rx_empty_r  <= 1'b1;
         rx_head_r   <= BYTE_ZERO_C;
      end else begin
         if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= SEQ_data_In;
            rx_wr_ptr_r           <= rx_wr_ptr_r + PTR_ONE_C;
         end
         rx_rd_ptr_r <= rx_rd_ptr_nxt_s;
         rx_count_r  <= rx_count_nxt_s;
         rx_empty_r  <= (rx_count_nxt_s == CNT_ZERO_C);
         rx_head_r   <= rx_head_nxt_s;
      end
   end

   // Frame sequencing FSM with registered slave select, start, data and status
   always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh) begin
      if (SPI_MASTER_RESET_InHigh) begin
         state_r      <= ST_IDLE;
         wait_cnt_r   <= 4'd0;
         bytes_left_r <= CNT_ZERO_C;
         ss_r         <= 1'b1;
         start_r      <= 1'b0;
         data_r       <= BYTE_ZERO_C;
         frame_done_r <= 1'b0;
         overrun_r    <= 1'b0;
         busy_r       <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
         wd_r         <= 8'd0;
         timeout_r    <= 1'b0;
`endif
      end else begin
         start_r      <= 1'b0;
         frame_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (go_accept_s) begin
                  bytes_left_r <= tx_count_r;
                  overrun_r    <= 1'b0;
                  ss_r         <= 1'b0;
                  busy_r       <= 1'b1;
                  wait_cnt_r   <= 4'd0;
                  state_r      <= ST_SETUP;
`ifdef SPI_SEQ_TIMEOUT_EN
                  timeout_r    <= 1'b0;
`endif
               end else begin
                  ss_r   <= 1'b1;
                  busy_r <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (load_evt_s) begin
                  start_r    <= 1'b1;
                  data_r     <= tx_mem_r[tx_rd_ptr_r];
                  wait_cnt_r <= 4'd0;
                  state_r    <= ST_LOAD;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 4'd1;
               end
            end
            ST_LOAD: begin
               // start was raised on entry; the engine sees exactly one cycle of it
               state_r <= ST_WAIT_DONE;
`ifdef SPI_SEQ_TIMEOUT_EN
               wd_r    <= 8'd0;
`endif
            end
            ST_WAIT_DONE: begin
               if (SEQ_newData_In) begin
                  if (overrun_evt_s) begin
                     overrun_r <= 1'b1;
                  end
                  bytes_left_r <= bytes_left_r - CNT_ONE_C;
                  wait_cnt_r   <= 4'd0;
                  state_r      <= ST_GAP;
               end
`ifdef SPI_SEQ_TIMEOUT_EN
               else if (wd_r == TO_LAST_C) begin
                  // engine never answered: drop the frame and report it
                  bytes_left_r <= CNT_ZERO_C;
                  ss_r         <= 1'b1;
                  frame_done_r <= 1'b1;
                  timeout_r    <= 1'b1;
                  state_r      <= ST_HOLD;
               end else begin
                  wd_r <= wd_r + 8'd1;
               end
`else
               else begin
                  state_r <= ST_WAIT_DONE;
               end
`endif
            end
            ST_GAP: begin
               if (wait_cnt_r == GAP_LAST_C) begin
                  wait_cnt_r <= 4'd0;
                  if (load_evt_s) begin
                     start_r <= 1'b1;
                     data_r  <= tx_mem_r[tx_rd_ptr_r];
                     state_r <= ST_LOAD;
                  end else begin
                     ss_r         <= 1'b1;
                     frame_done_r <= 1'b1;
                     state_r      <= ST_HOLD;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + 4'd1;
               end
            end
            ST_HOLD: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               ss_r    <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign SEQ_txFull_Out    = tx_full_r;
   assign SEQ_rxData_Out    = rx_head_r;
   assign SEQ_rxEmpty_Out   = rx_empty_r;
   assign SEQ_frameDone_Out = frame_done_r;
   assign SEQ_rxOverrun_Out = overrun_r;
   assign SEQ_SS_OutLow     = ss_r;
   assign SEQ_start_Out     = start_r;
   assign SEQ_data_Out      = data_r;
   assign SEQ_busy_Out      = busy_r;
`ifdef SPI_SEQ_TIMEOUT_EN
   assign SEQ_timeout_Out   = timeout_r;
`endif

endmodule
